// File: rtl/dmem_if.sv
// CPU data-memory bus: request side (DMAdd/DataIn/DMR/DMW) and response side
// (DataOut/Ready/Stall/AddrErr) grouped as one interface.
interface dmem_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] DMAdd;
  logic [31:0]       DataIn;
  logic              DMR;
  logic              DMW;
  logic [31:0]       DataOut;
  logic              Ready;
  logic              Stall;
  logic              AddrErr;

  modport master (
    output DMAdd, DataIn, DMR, DMW,
    input  DataOut, Ready, Stall, AddrErr
  );

  modport slave (
    input  DMAdd, DataIn, DMR, DMW,
    output DataOut, Ready, Stall, AddrErr
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency word RAM with Stall/Ready handshake and misalign flag.
// Optional DMEM_MMIO_EN maps the last word to a free-running 32-bit cycle counter.
module dmem_responder #(
  parameter int ADDR_W   = 7,
  parameter int DEPTH    = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);
  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            stateReg, stateNext;
  logic [3:0]        waitCntReg, waitCntNext;
  logic [IDX_W-1:0]  idxReg;
  logic [31:0]       dataReg;
  logic              writeReg;
  logic              misReg;
  logic [31:0]       dataOutReg;
  logic              addrErrReg;
  logic [31:0]       mem [DEPTH];

  logic              req;
  logic              enterDone;
  logic              stall;
  logic [IDX_W-1:0]  curIdx;
  logic              curMis;
  logic [IDX_W-1:0]  accIdx;
  logic [31:0]       accData;
  logic              accWrite;
  logic              accMis;
  logic              mmioHit;
  logic              ramWe;
  logic [31:0]       readWord;

  assign req    = bus.DMR | bus.DMW;
  // High address bits beyond DEPTH wrap.
  assign curIdx = IDX_W'(32'(bus.DMAdd[ADDR_W-1:2]) % DEPTH);
  assign curMis = |bus.DMAdd[1:0];

  // With WAIT_CYC=0 the access completes on the accepting edge, so use live inputs.
  assign accIdx   = (stateReg == IDLE) ? curIdx      : idxReg;
  assign accData  = (stateReg == IDLE) ? bus.DataIn  : dataReg;
  assign accWrite = (stateReg == IDLE) ? bus.DMW     : writeReg;
  assign accMis   = (stateReg == IDLE) ? curMis      : misReg;

  always_comb begin
    stateNext   = stateReg;
    waitCntNext = waitCntReg;
    enterDone   = 1'b0;
    stall       = 1'b0;
    case (stateReg)
      IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (WAIT_LAST == 4'd0) begin
            stateNext = DONE;
            enterDone = 1'b1;
          end else begin
            stateNext   = WAIT;
            waitCntNext = 4'd1;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (waitCntReg >= WAIT_LAST) begin
          stateNext = DONE;
          enterDone = 1'b1;
        end else begin
          waitCntNext = waitCntReg + 4'd1;
        end
      end
      DONE: begin
        stateNext   = IDLE;
        waitCntNext = 4'd0;
      end
      default: begin
        stateNext   = IDLE;
        waitCntNext = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= IDLE;
      waitCntReg <= 4'd0;
      idxReg     <= '0;
      dataReg    <= 32'd0;
      writeReg   <= 1'b0;
      misReg     <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
      if (stateReg == IDLE && req) begin
        idxReg   <= curIdx;
        dataReg  <= bus.DataIn;
        writeReg <= bus.DMW;
        misReg   <= curMis;
      end
    end
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] cycleCntReg;

  assign mmioHit = (accIdx == LAST_IDX);
  // A read returns the value the counter takes on the completing edge.
  assign readWord = mmioHit ? (cycleCntReg + 32'd1) : mem[accIdx];

  always_ff @(posedge clk) begin
    if (rst) begin
      cycleCntReg <= 32'd0;
    end else if (enterDone && accWrite && !accMis && mmioHit) begin
      cycleCntReg <= accData;
    end else begin
      cycleCntReg <= cycleCntReg + 32'd1;
    end
  end
`else
  assign mmioHit  = 1'b0;
  assign readWord = mem[accIdx];
`endif

  assign ramWe = enterDone && accWrite && !accMis && !mmioHit;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (ramWe) begin
      mem[accIdx] <= accData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataOutReg <= 32'd0;
      addrErrReg <= 1'b0;
    end else begin
      if (enterDone && !accWrite) begin
        dataOutReg <= accMis ? 32'd0 : readWord;
      end
      if (enterDone) begin
        addrErrReg <= accMis;
      end else if (stateReg == DONE) begin
        addrErrReg <= 1'b0;
      end
    end
  end

  assign bus.DataOut = dataOutReg;
  assign bus.AddrErr = addrErrReg;
  assign bus.Ready   = (stateReg == DONE);
  assign bus.Stall   = stall;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases then random accesses checked against a
// word-array / cycle-counter reference model. Define DMEM_MMIO_EN to match the DUT build.
module tb_dmem_responder;
  localparam int WAIT_CYC = 2;
  localparam int DEPTH    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(7)) bus();

  dmem_responder #(.ADDR_W(7), .DEPTH(DEPTH), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int edgeCnt  = 0;
  always @(posedge clk) edgeCnt++;

  // Reference model: plain word array, last read value, counter as base + elapsed edges.
  logic [31:0] modelMem [DEPTH];
  logic [31:0] modelOut;
  logic [31:0] ctrBase;
  int          ctrEdge;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic modelReset(input int edgeIdx);
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'd0;
    modelOut = 32'd0;
    ctrBase  = 32'd0;
    ctrEdge  = edgeIdx;
  endtask

  task automatic idleBus();
    bus.DMR    = 1'b0;
    bus.DMW    = 1'b0;
    bus.DMAdd  = 7'd0;
    bus.DataIn = 32'd0;
  endtask

  task automatic doReset();
    @(negedge clk);
    idleBus();
    rst = 1'b1;
    @(negedge clk);
    modelReset(edgeCnt);
    rst = 1'b0;
  endtask

  // One complete access starting from an idle negedge; returns at the negedge after Ready.
  task automatic access(input bit w, input bit r, input logic [6:0] addr,
                        input logic [31:0] data, input string tag);
    int lat;
    int word;
    int doneEdge;
    bit mis;
    bit mmio;
    bus.DMAdd  = addr;
    bus.DataIn = data;
    bus.DMR    = r;
    bus.DMW    = w;
    #1;
    check({tag, "_stall_req"}, 32'(bus.Stall), 32'd1);
    @(negedge clk);
    idleBus();
    lat = 1;
    while (bus.Ready !== 1'b1 && lat < 20) begin
      check({tag, "_stall_wait"}, 32'(bus.Stall), 32'd1);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(WAIT_CYC + 1));
    doneEdge = edgeCnt;

    mis  = (addr[1:0] != 2'b00);
    word = int'(addr[6:2]) % DEPTH;
`ifdef DMEM_MMIO_EN
    mmio = (word == DEPTH - 1);
`else
    mmio = 1'b0;
`endif
    if (w) begin
      if (!mis) begin
        if (mmio) begin
          ctrBase = data;
          ctrEdge = doneEdge;
        end else begin
          modelMem[word] = data;
        end
      end
    end else if (mis) begin
      modelOut = 32'd0;
    end else if (mmio) begin
      modelOut = ctrBase + 32'(doneEdge - ctrEdge);
    end else begin
      modelOut = modelMem[word];
    end

    check({tag, "_ready"},   32'(bus.Ready),   32'd1);
    check({tag, "_dataout"}, bus.DataOut,      modelOut);
    check({tag, "_addrerr"}, 32'(bus.AddrErr), 32'(mis));
    check({tag, "_stall_done"}, 32'(bus.Stall), 32'd0);
    @(negedge clk);
    check({tag, "_ready_off"},   32'(bus.Ready),   32'd0);
    check({tag, "_addrerr_off"}, 32'(bus.AddrErr), 32'd0);
  endtask

  initial begin
    logic [6:0]  rAddr;
    logic [31:0] rData;
    int          op;
    idleBus();
    modelReset(0);
    repeat (2) @(negedge clk);
    doReset();
    check("rst_ready",   32'(bus.Ready),   32'd0);
    check("rst_dataout", bus.DataOut,      32'd0);
    check("rst_addrerr", 32'(bus.AddrErr), 32'd0);
    check("rst_stall",   32'(bus.Stall),   32'd0);

    access(1'b0, 1'b1, 7'h04, 32'd0, "t1_read");
    access(1'b1, 1'b0, 7'h08, 32'hDEADBEEF, "t2_write");
    access(1'b0, 1'b1, 7'h08, 32'd0, "t2_read");
    access(1'b1, 1'b0, 7'h05, 32'h00001234, "t3_miswrite");
    access(1'b0, 1'b1, 7'h04, 32'd0, "t3_read");
    access(1'b1, 1'b1, 7'h0C, 32'h00000055, "t4_both");
    access(1'b0, 1'b1, 7'h0C, 32'd0, "t4_read");
    access(1'b0, 1'b1, 7'h0B, 32'd0, "t4_misread");

    // Reset during WAIT aborts the write and suppresses Ready.
    bus.DMAdd  = 7'h10;
    bus.DataIn = 32'hA5A5A5A5;
    bus.DMW    = 1'b1;
    @(negedge clk);
    idleBus();
    rst = 1'b1;
    @(negedge clk);
    modelReset(edgeCnt);
    rst = 1'b0;
    check("t5_ready_rst", 32'(bus.Ready), 32'd0);
    check("t5_dataout_rst", bus.DataOut, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t5_no_ready", 32'(bus.Ready), 32'd0);
      @(negedge clk);
    end
    access(1'b0, 1'b1, 7'h10, 32'd0, "t5_read");

    access(1'b1, 1'b0, 7'h7C, 32'hFFFFFFFE, "t6_write");
    access(1'b0, 1'b1, 7'h7C, 32'd0, "t6_read");

    for (int n = 0; n < 60; n++) begin
      op    = int'($urandom_range(0, 3));
      rData = $urandom;
      case ($urandom_range(0, 5))
        0:       rAddr = 7'h7C;
        1:       rAddr = 7'($urandom_range(0, 127));
        default: rAddr = {5'($urandom_range(0, 31)), 2'b00};
      endcase
      case (op)
        0, 1:    access(1'b0, 1'b1, rAddr, rData, "rnd_read");
        2:       access(1'b1, 1'b0, rAddr, rData, "rnd_write");
        default: access(1'b1, 1'b1, rAddr, rData, "rnd_both");
      endcase
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
